imem_dmem_arbiter: RTL
======================

Name: imem_dmem_arbiter

Overview:
- Shares one single-port, fixed-latency unified memory between the IF stage (instruction fetch) and the MEM stage (loads/stores) of the pipelined core.
- Grants one access at a time and sequences it through issue, wait and response.
- Returns data to the owning stage and drives per-stage stall requests that the pipeline hazard/stall logic ORs into its stall/flush decisions.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- DATA_WIDTH, 32, data word width.
- LATENCY, 2, cycles from the mem_req cycle to the cycle mem_rdata is valid. Legal range 1..15.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- IReqF  input  1  fetch request, held high until IValidF
- IAddrF  input  ADDR_WIDTH  fetch address, stable while IReqF
- IKillF  input  1  fetch redirect; discards any in-flight fetch response
- IRdataF  output  DATA_WIDTH  fetched instruction
- IValidF  output  1  one-cycle fetch completion pulse
- DReqM  input  1  data request, held high until DValidM
- DWeM  input  1  1 = store, 0 = load
- DAddrM  input  ADDR_WIDTH  data address
- DWdataM  input  DATA_WIDTH  store data
- DBeM  input  DATA_WIDTH/8  store byte enables
- DRdataM  output  DATA_WIDTH  load data
- DValidM  output  1  one-cycle data completion pulse (loads and stores)
- StallF  output  1  IReqF && !IValidF
- StallM  output  1  DReqM && !DValidM
- mem_req  output  1  one-cycle issue strobe to memory
- mem_we  output  1  write enable, held for the access
- mem_addr  output  ADDR_WIDTH  held for the access
- mem_wdata  output  DATA_WIDTH  held for the access
- mem_be  output  DATA_WIDTH/8  byte enables; all ones for reads
- mem_rdata  input  DATA_WIDTH  read data, valid LATENCY cycles after mem_req

Behaviour:
- States: IDLE, BUSY, RESP. Registers:
  - owner (0 = I, 1 = D)
  - cnt (4 bits)
  - last_d (fairness bit)
  - kill_pend
- IDLE, no request: stay in IDLE.
- IDLE, request present: choose owner.
  - Only one requester: it wins.
  - Both requesting: D wins unless last_d=1, in which case I wins.
  - Capture addr/we/wdata/be into mem_* registers. For I and for D loads, we=0 and be=all ones.
  - Go to BUSY with cnt=LATENCY; set last_d = (owner==D).
- BUSY: mem_req=1 only on the first BUSY cycle; cnt decrements each cycle.
  - When cnt reaches 0, capture mem_rdata into IRdataF (owner I) or DRdataM (owner D load), then go to RESP.
  - Stores leave DRdataM unchanged.
- RESP: pulse IValidF or DValidM for exactly one cycle, then go to IDLE.
  - If owner=I and kill_pend=1, IValidF is suppressed and IRdataF is not updated.
- Timing: request sampled in cycle 0 → mem_req in cycle 1 → capture in cycle 1+LATENCY → Valid in cycle 2+LATENCY → next request sampled in cycle 3+LATENCY.
  - Back-to-back throughput is one access per LATENCY+3 cycles.
- IKillF:
  - While owner=I in BUSY/RESP, set kill_pend; it is cleared on return to IDLE.
  - In the IDLE grant cycle, IKillF blocks the I grant for that cycle, so D may be granted instead.
  - IKillF during a D access has no effect.
- The memory access cannot be aborted; a killed fetch still occupies the full access time.
- Requests arriving while BUSY/RESP wait and are evaluated in IDLE. Request inputs are ignored outside IDLE.
- StallF/StallM are combinational from the request inputs and the registered Valid pulses.
- Reset (any state, including mid-access):
  - State returns to IDLE; cnt, owner, last_d and kill_pend clear.
  - mem_req, mem_we, IValidF and DValidM go to 0.
  - mem_addr, mem_wdata, mem_be, IRdataF and DRdataM go to 0.
  - Memory is reset together with the arbiter, so no stale response is consumed.
- Invariants: mem_req never high on two consecutive cycles; at most one Valid per access; IValidF and DValidM never high together.

Test Plan:
- LATENCY=2, IReqF=1 with IAddrF=0x100 at cycle 0, memory returns 0x00500093 → mem_req=1 in cycle 1 with mem_addr=0x100 and mem_we=0; IValidF=1 in cycle 4 with IRdataF=0x00500093; StallF high in cycles 0-3.
- Both DReqM (load, 0x2000) and IReqF asserted in cycle 0 with last_d=0 → D granted first (DValidM in cycle 4), I granted in cycle 5 (IValidF in cycle 9). Both held continuously → grants alternate D, I, D.
- Store with DAddrM=0x2004, DWdataM=0xDEADBEEF, DBeM=0011 → mem_we=1 and mem_be=0011 held for cycles 1-3; DValidM pulses in cycle 4; DRdataM unchanged.
- IKillF=1 in cycle 2 of a fetch → no IValidF in cycle 4 and IRdataF unchanged; a new fetch sampled in cycle 5 completes normally in cycle 9.
- rst asserted in cycle 2 of a load → cycle 3: state IDLE, mem_req=0, DValidM=0, all data outputs 0; request reissued after reset completes with full latency.
- LATENCY=1 build: single access → mem_req in cycle 1, Valid in cycle 3; mem_req is never high on two consecutive cycles across 100 random request patterns.

Source files
------------

// File: rtl/imem_dmem_arbiter_if.sv
// Core-side fetch/data request bus plus the unified memory port.
// The arbiter uses the slave view; the pipeline/memory environment uses the master view.
interface imem_dmem_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) ();
  localparam int unsigned BeWidth = DATA_WIDTH / 8;

  logic                  IReqF;
  logic [ADDR_WIDTH-1:0] IAddrF;
  logic                  IKillF;
  logic [DATA_WIDTH-1:0] IRdataF;
  logic                  IValidF;

  logic                  DReqM;
  logic                  DWeM;
  logic [ADDR_WIDTH-1:0] DAddrM;
  logic [DATA_WIDTH-1:0] DWdataM;
  logic [BeWidth-1:0]    DBeM;
  logic [DATA_WIDTH-1:0] DRdataM;
  logic                  DValidM;

  logic                  StallF;
  logic                  StallM;

  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [BeWidth-1:0]    mem_be;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport slave (
    input  IReqF, IAddrF, IKillF, DReqM, DWeM, DAddrM, DWdataM, DBeM, mem_rdata,
    output IRdataF, IValidF, DRdataM, DValidM, StallF, StallM,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );

  modport master (
    output IReqF, IAddrF, IKillF, DReqM, DWeM, DAddrM, DWdataM, DBeM, mem_rdata,
    input  IRdataF, IValidF, DRdataM, DValidM, StallF, StallM,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );
endinterface

// File: rtl/imem_dmem_arbiter.sv
// Arbitrates the IF and MEM stages onto one fixed-latency single-port memory,
// one access at a time: grant in IDLE, issue/wait in BUSY, completion pulse in RESP.
module imem_dmem_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LATENCY    = 2
) (
  input logic                 clk,
  input logic                 rst,
  imem_dmem_arbiter_if.slave  bus_io
);
  localparam int unsigned BeWidth = DATA_WIDTH / 8;
  localparam logic [3:0]  CntInit = 4'(LATENCY);

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  state_e                state_q, state_d;
  logic                  owner_q, owner_d;  // 1 = data port
  logic [3:0]            cnt_q, cnt_d;
  logic                  last_dat_q, last_dat_d;
  logic                  kill_pend_q, kill_pend_d;
  logic                  mem_req_q, mem_req_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [BeWidth-1:0]    mem_be_q, mem_be_d;
  logic [DATA_WIDTH-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;
  logic                  i_valid_q, i_valid_d;
  logic                  d_valid_q, d_valid_d;

  logic                  i_req_ok;
  logic                  fetch_killed;
  logic                  grant_dat;

  // A redirect in the grant cycle withdraws the fetch so data can go first.
  assign i_req_ok     = bus_io.IReqF && !bus_io.IKillF;
  assign fetch_killed = kill_pend_q || bus_io.IKillF;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    last_dat_d  = last_dat_q;
    kill_pend_d = kill_pend_q;
    mem_req_d   = 1'b0;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    i_valid_d   = 1'b0;
    d_valid_d   = 1'b0;
    grant_dat   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (i_req_ok || bus_io.DReqM) begin
          grant_dat  = bus_io.DReqM && (!i_req_ok || !last_dat_q);
          owner_d    = grant_dat;
          last_dat_d = grant_dat;
          cnt_d      = CntInit;
          mem_req_d  = 1'b1;
          state_d    = StBusy;
          if (grant_dat) begin
            mem_we_d    = bus_io.DWeM;
            mem_addr_d  = bus_io.DAddrM;
            mem_wdata_d = bus_io.DWdataM;
            mem_be_d    = bus_io.DWeM ? bus_io.DBeM : {BeWidth{1'b1}};
          end else begin
            mem_we_d    = 1'b0;
            mem_addr_d  = bus_io.IAddrF;
            mem_wdata_d = '0;
            mem_be_d    = {BeWidth{1'b1}};
          end
        end
      end
      StBusy: begin
        if (!owner_q && bus_io.IKillF) begin
          kill_pend_d = 1'b1;
        end
        if (cnt_q == 4'd0) begin
          state_d = StResp;
          if (owner_q) begin
            if (!mem_we_q) begin
              d_rdata_d = bus_io.mem_rdata;
            end
            d_valid_d = 1'b1;
          end else if (!fetch_killed) begin
            i_rdata_d = bus_io.mem_rdata;
            i_valid_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp: begin
        kill_pend_d = 1'b0;
        state_d     = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      owner_q     <= 1'b0;
      cnt_q       <= 4'd0;
      last_dat_q  <= 1'b0;
      kill_pend_q <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      i_valid_q   <= 1'b0;
      d_valid_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      last_dat_q  <= last_dat_d;
      kill_pend_q <= kill_pend_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
      i_valid_q   <= i_valid_d;
      d_valid_q   <= d_valid_d;
    end
  end

  assign bus_io.IRdataF   = i_rdata_q;
  assign bus_io.IValidF   = i_valid_q;
  assign bus_io.DRdataM   = d_rdata_q;
  assign bus_io.DValidM   = d_valid_q;
  assign bus_io.StallF    = bus_io.IReqF && !i_valid_q;
  assign bus_io.StallM    = bus_io.DReqM && !d_valid_q;
  assign bus_io.mem_req   = mem_req_q;
  assign bus_io.mem_we    = mem_we_q;
  assign bus_io.mem_addr  = mem_addr_q;
  assign bus_io.mem_wdata = mem_wdata_q;
  assign bus_io.mem_be    = mem_be_q;
endmodule
